ahb_slave_mux: RTL and testbench
================================

# ahb_slave_mux

Parametrised AHB-Lite slave-to-master response multiplexer with a built-in default slave. The block registers the decoded slave index during the address phase and routes that slave's hrdata/hreadyout/hresp back to the master during the data phase. Unmapped indices go to an internal default slave. It sits between the address decoder and the master in the AHB-Lite interconnect and replaces the fixed three-slave combinational read mux.

## Interface
- NUM_SLAVES, 3: number of attached slaves, 1..(2^SEL_WIDTH).
- DATA_WIDTH, 32: data bus width.
- SEL_WIDTH, 2: width of decoded slave index.

- hclk  input  1  bus clock; all state on rising edge.
- hreset  input  1  one clock; reset is asynchronous and active-high.
- sel  input  SEL_WIDTH  decoder slave index for the current address phase.
- htrans  input  2  master transfer type for the current address phase (00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ).
- hrdata_bus  input  NUM_SLAVES*DATA_WIDTH  slave read data; slave k occupies bits [k*DATA_WIDTH +: DATA_WIDTH].
- hreadyout_bus  input  NUM_SLAVES  slave k ready at bit k.
- hresp_bus  input  NUM_SLAVES  slave k response at bit k (1 = ERROR).
- hrdata  output  DATA_WIDTH  read data to master.
- hreadyout  output  1  HREADY to master and to all slaves.
- hresponse  output  1  HRESP to master.

## Operation
- FSM states: IDLE (no data phase owned), SLV (data phase owned by slave dp_sel), ERR1, ERR2 (default-slave error).
- Address phase is sampled on a rising hclk edge only when hreadyout = 1. When hreadyout = 0, the state and dp_sel hold.
- Next state on a sampled edge:
  - htrans IDLE or BUSY → IDLE.
  - htrans NONSEQ/SEQ with sel < NUM_SLAVES → SLV, dp_sel <= sel.
  - htrans NONSEQ/SEQ with sel ≥ NUM_SLAVES → ERR1.
- ERR1 → ERR2 unconditionally on the next edge. ERR2 is a normal sampling point because hreadyout = 1.
- Outputs by state:
  - IDLE: hrdata = 0, hreadyout = 1, hresponse = 0.
  - SLV: hrdata, hreadyout and hresponse are the fields of slave dp_sel.
  - ERR1: hrdata = 0, hreadyout = 0, hresponse = 1.
  - ERR2: hrdata = 0, hreadyout = 1, hresponse = 1.
- The mux passes slave ERROR responses through unmodified. It never extends or shortens a slave's two-cycle error.
- NUM_SLAVES = 2^SEL_WIDTH: no unmapped index exists and ERR1/ERR2 are unreachable.
- Slave index decode is one-hot internally. dp_sel outside the valid range cannot occur.

## Timing
- Reset values: state = IDLE, dp_sel = 0. Hence hrdata = 0, hreadyout = 1, hresponse = 0.
- Reset is asynchronous. Assertion mid-transfer (any state, including ERR1 or a SLV wait state) forces IDLE outputs immediately, without waiting for a clock edge.
- Zero added latency: outputs are combinational from registered state/dp_sel and the slave inputs. A slave's hreadyout reaches the master in the same cycle.
- Data phase begins on the edge after the sampled address phase.
- Slave wait states: while SLV and hreadyout_bus[dp_sel] = 0, the next address phase (sel, htrans) is held off and resampled each cycle until ready.
- Back-to-back transfers to different slaves switch dp_sel on the completing edge with no bubble.
- Default error: exactly 2 data-phase cycles (ERR1, ERR2). A transfer presented during ERR2 is sampled at the end of ERR2.

## Configuration
- Macro: AHB_SLAVE_MUX_DEFSLV_ERR_EN.
- Defined: unmapped NONSEQ/SEQ transfers take the two-cycle ERROR path (ERR1 → ERR2) as described above.
- Undefined: the ERR1/ERR2 states are not built. Unmapped NONSEQ/SEQ transfers go to IDLE, giving a zero-wait OKAY with hrdata = 0.

## Test plan
- Reset: assert hreset mid-SLV with slave 1 stalling (hreadyout_bus = 3'b101) → hreadyout = 1, hresponse = 0, hrdata = 0 with no clock edge. After release, IDLE is held with htrans = 00.
- Routing: NONSEQ to sel = 0, 1, 2 on consecutive cycles, with slave k driving hrdata = 32'hA000_000k → each data phase shows 32'hA000_000k one cycle after its address phase.
- Wait states: sel = 2, slave 2 holds hreadyout low 3 cycles, while the master presents sel = 0 NONSEQ → hreadyout = 0 for 3 cycles and dp_sel stays 2. Slave 0 is captured only on the completing edge.
- Default slave: sel = 3 NONSEQ with the macro defined → hreadyout/hresponse = 0/1 then 1/1, hrdata = 0. With the macro undefined → 1/0 in one cycle.
- Slave error pass-through: slave 1 drives hresp = 1 for 2 cycles with hreadyout 0 then 1 → identical sequence on hresponse/hreadyout.
- Idle/busy: htrans = 01 to sel = 1 → next cycle IDLE outputs (hreadyout = 1, hresponse = 0, hrdata = 0), ignoring slave 1 inputs.

Source files
------------

// File: rtl/ahb_slave_mux.sv
// AHB-Lite slave response multiplexer with built-in default slave.
// Define AHB_SLAVE_MUX_DEFSLV_ERR_EN to give unmapped transfers a two-cycle ERROR response.
module ahb_slave_mux #(
    parameter int unsigned NUM_SLAVES = 3,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned SEL_WIDTH  = 2
) (
    input  logic                             hclk,
    input  logic                             hreset,
    input  logic [SEL_WIDTH-1:0]             sel,
    input  logic [1:0]                       htrans,
    input  logic [NUM_SLAVES*DATA_WIDTH-1:0] hrdata_bus,
    input  logic [NUM_SLAVES-1:0]            hreadyout_bus,
    input  logic [NUM_SLAVES-1:0]            hresp_bus,
    output logic [DATA_WIDTH-1:0]            hrdata,
    output logic                             hreadyout,
    output logic                             hresponse
);

`ifdef AHB_SLAVE_MUX_DEFSLV_ERR_EN
    typedef enum logic [1:0] {ST_IDLE, ST_SLV, ST_ERR1, ST_ERR2} state_t;
`else
    typedef enum logic [0:0] {ST_IDLE, ST_SLV} state_t;
`endif

    state_t                state;
    logic [NUM_SLAVES-1:0] dp_oh;
    logic [NUM_SLAVES-1:0] sel_oh;
    logic                  mapped;

    always_comb begin
        sel_oh = '0;
        for (int unsigned k = 0; k < NUM_SLAVES; k++) begin
            sel_oh[k] = (32'(sel) == k);
        end
        mapped = (32'(sel) < NUM_SLAVES);
    end

    always_ff @(posedge hclk or posedge hreset) begin
        if (hreset) begin
            state <= ST_IDLE;
            dp_oh <= NUM_SLAVES'(1);
        end else begin
            case (state)
`ifdef AHB_SLAVE_MUX_DEFSLV_ERR_EN
                ST_ERR1: state <= ST_ERR2;
`endif
                default: begin
                    if (hreadyout) begin
                        if (!htrans[1]) begin
                            state <= ST_IDLE;
                        end else if (mapped) begin
                            state <= ST_SLV;
                            dp_oh <= sel_oh;
                        end else begin
`ifdef AHB_SLAVE_MUX_DEFSLV_ERR_EN
                            state <= ST_ERR1;
`else
                            state <= ST_IDLE;
`endif
                        end
                    end
                end
            endcase
        end
    end

    // dp_oh is strictly one-hot, so an AND-OR mux selects exactly one slave.
    always_comb begin
        hrdata    = '0;
        hreadyout = 1'b1;
        hresponse = 1'b0;
        case (state)
            ST_SLV: begin
                hreadyout = 1'b0;
                for (int unsigned k = 0; k < NUM_SLAVES; k++) begin
                    hrdata    = hrdata | (hrdata_bus[k*DATA_WIDTH +: DATA_WIDTH] & {DATA_WIDTH{dp_oh[k]}});
                    hreadyout = hreadyout | (hreadyout_bus[k] & dp_oh[k]);
                    hresponse = hresponse | (hresp_bus[k] & dp_oh[k]);
                end
            end
`ifdef AHB_SLAVE_MUX_DEFSLV_ERR_EN
            ST_ERR1: begin
                hreadyout = 1'b0;
                hresponse = 1'b1;
            end
            ST_ERR2: begin
                hreadyout = 1'b1;
                hresponse = 1'b1;
            end
`endif
            default: ;
        endcase
    end

endmodule

// File: tb/tb_ahb_slave_mux.sv
// Self-checking bench for ahb_slave_mux with a transaction-level reference model.
// Honours AHB_SLAVE_MUX_DEFSLV_ERR_EN to pick the expected default-slave behaviour.
module tb_ahb_slave_mux;

    logic        hclk = 1'b0;
    logic        hreset;
    logic [1:0]  sel;
    logic [1:0]  htrans;
    logic [95:0] hrdata_bus;
    logic [2:0]  hreadyout_bus;
    logic [2:0]  hresp_bus;
    logic [31:0] hrdata;
    logic        hreadyout;
    logic        hresponse;

    int passed = 0;
    int total  = 0;

    // Model: who owns the current data phase (0 none, 1 slave, 2 default slave).
    int owner = 0;
    int own_idx = 0;
    int def_cycles = 0;

    logic [31:0] exp_d;
    logic        exp_r;
    logic        exp_e;

    always #5 hclk = ~hclk;

    ahb_slave_mux #(.NUM_SLAVES(3), .DATA_WIDTH(32), .SEL_WIDTH(2)) dut (
        .hclk(hclk), .hreset(hreset), .sel(sel), .htrans(htrans),
        .hrdata_bus(hrdata_bus), .hreadyout_bus(hreadyout_bus), .hresp_bus(hresp_bus),
        .hrdata(hrdata), .hreadyout(hreadyout), .hresponse(hresponse)
    );

    task automatic model_expect();
        if (hreset || owner == 0) begin
            exp_d = '0; exp_r = 1'b1; exp_e = 1'b0;
        end else if (owner == 1) begin
            exp_d = hrdata_bus[own_idx*32 +: 32];
            exp_r = hreadyout_bus[own_idx];
            exp_e = hresp_bus[own_idx];
        end else begin
            exp_d = '0; exp_r = (def_cycles != 0); exp_e = 1'b1;
        end
    endtask

    // Advance one clock, updating the model from the transfer presented this cycle.
    task automatic tick();
        model_expect();
        if (hreset) begin
            owner = 0;
        end else if (exp_r) begin
            if (htrans == 2'b10 || htrans == 2'b11) begin
                if (sel < 3) begin
                    owner = 1; own_idx = int'(sel);
                end else begin
`ifdef AHB_SLAVE_MUX_DEFSLV_ERR_EN
                    owner = 2; def_cycles = 0;
`else
                    owner = 0;
`endif
                end
            end else begin
                owner = 0;
            end
        end else if (owner == 2) begin
            def_cycles++;
        end
        @(posedge hclk);
        #1;
    endtask

    function automatic logic [95:0] tagged_data();
        return {32'hA000_0002, 32'hA000_0001, 32'hA000_0000};
    endfunction

    task automatic test_reset();
        hreset = 1'b1; sel = '0; htrans = 2'b00;
        hrdata_bus = {3{32'hDEAD_BEEF}}; hreadyout_bus = 3'b111; hresp_bus = 3'b000;
        #1;
        total++;
        if ({hrdata, hreadyout, hresponse} !== {32'h0, 1'b1, 1'b0}) begin
            $display("FAIL reset_initial got d=%h r=%b e=%b want d=0 r=1 e=0", hrdata, hreadyout, hresponse);
        end else passed++;
        tick(); tick();
        hreset = 1'b0;
        tick();
        sel = 2'd1; htrans = 2'b10;
        tick();
        hreadyout_bus = 3'b101; htrans = 2'b00; #1;
        total++;
        if ({hrdata, hreadyout} !== {32'hDEAD_BEEF, 1'b0}) begin
            $display("FAIL reset_stall_setup got d=%h r=%b want d=deadbeef r=0", hrdata, hreadyout);
        end else passed++;
        hreset = 1'b1; owner = 0; #1;
        total++;
        if ({hrdata, hreadyout, hresponse} !== {32'h0, 1'b1, 1'b0}) begin
            $display("FAIL reset_async got d=%h r=%b e=%b want d=0 r=1 e=0", hrdata, hreadyout, hresponse);
        end else passed++;
        tick();
        hreset = 1'b0; hreadyout_bus = 3'b111;
        tick(); #1;
        total++;
        if ({hrdata, hreadyout, hresponse} !== {32'h0, 1'b1, 1'b0}) begin
            $display("FAIL reset_release_idle got d=%h r=%b e=%b want d=0 r=1 e=0", hrdata, hreadyout, hresponse);
        end else passed++;
    endtask

    task automatic test_routing();
        hrdata_bus = tagged_data(); hreadyout_bus = 3'b111; hresp_bus = 3'b000;
        htrans = 2'b10; sel = 2'd0;
        tick();
        for (int k = 1; k <= 3; k++) begin
            if (k < 3) sel = 2'(k); else htrans = 2'b00;
            #1;
            total++;
            if (hrdata !== 32'hA000_0000 + 32'(k - 1) || hreadyout !== 1'b1) begin
                $display("FAIL routing_slave%0d got d=%h r=%b want d=%h r=1", k - 1, hrdata, hreadyout, 32'hA000_0000 + 32'(k - 1));
            end else passed++;
            tick();
        end
    endtask

    task automatic test_wait_states();
        hrdata_bus = tagged_data(); hreadyout_bus = 3'b111;
        htrans = 2'b10; sel = 2'd2;
        tick();
        sel = 2'd0; hreadyout_bus = 3'b011;
        for (int i = 0; i < 3; i++) begin
            #1;
            total++;
            if (hreadyout !== 1'b0 || hrdata !== 32'hA000_0002) begin
                $display("FAIL wait_cycle%0d got r=%b d=%h want r=0 d=a0000002", i, hreadyout, hrdata);
            end else passed++;
            tick();
        end
        hreadyout_bus = 3'b111; #1;
        total++;
        if (hreadyout !== 1'b1 || hrdata !== 32'hA000_0002) begin
            $display("FAIL wait_complete got r=%b d=%h want r=1 d=a0000002", hreadyout, hrdata);
        end else passed++;
        tick();
        htrans = 2'b00; #1;
        total++;
        if (hrdata !== 32'hA000_0000) begin
            $display("FAIL wait_next_slave0 got d=%h want d=a0000000", hrdata);
        end else passed++;
        tick();
    endtask

    task automatic test_default_slave();
        hrdata_bus = tagged_data(); hreadyout_bus = 3'b111;
        htrans = 2'b10; sel = 2'd3;
        tick();
        htrans = 2'b00; #1;
`ifdef AHB_SLAVE_MUX_DEFSLV_ERR_EN
        total++;
        if ({hrdata, hreadyout, hresponse} !== {32'h0, 1'b0, 1'b1}) begin
            $display("FAIL default_err1 got d=%h r=%b e=%b want d=0 r=0 e=1", hrdata, hreadyout, hresponse);
        end else passed++;
        tick();
        total++;
        if ({hrdata, hreadyout, hresponse} !== {32'h0, 1'b1, 1'b1}) begin
            $display("FAIL default_err2 got d=%h r=%b e=%b want d=0 r=1 e=1", hrdata, hreadyout, hresponse);
        end else passed++;
        tick();
`else
        total++;
        if ({hrdata, hreadyout, hresponse} !== {32'h0, 1'b1, 1'b0}) begin
            $display("FAIL default_okay got d=%h r=%b e=%b want d=0 r=1 e=0", hrdata, hreadyout, hresponse);
        end else passed++;
        tick();
`endif
        total++;
        if ({hrdata, hreadyout, hresponse} !== {32'h0, 1'b1, 1'b0}) begin
            $display("FAIL default_after got d=%h r=%b e=%b want d=0 r=1 e=0", hrdata, hreadyout, hresponse);
        end else passed++;
    endtask

    task automatic test_error_passthrough();
        hrdata_bus = tagged_data(); hreadyout_bus = 3'b111; hresp_bus = 3'b000;
        htrans = 2'b10; sel = 2'd1;
        tick();
        htrans = 2'b00; hresp_bus = 3'b010; hreadyout_bus = 3'b101; #1;
        total++;
        if ({hreadyout, hresponse} !== 2'b01) begin
            $display("FAIL slverr_first got r=%b e=%b want r=0 e=1", hreadyout, hresponse);
        end else passed++;
        tick();
        hreadyout_bus = 3'b111; #1;
        total++;
        if ({hreadyout, hresponse} !== 2'b11) begin
            $display("FAIL slverr_second got r=%b e=%b want r=1 e=1", hreadyout, hresponse);
        end else passed++;
        tick();
        hresp_bus = 3'b000;
    endtask

    task automatic test_idle_busy();
        htrans = 2'b01; sel = 2'd1;
        tick();
        htrans = 2'b00; hrdata_bus = {3{32'h5555_AAAA}}; hreadyout_bus = 3'b000; hresp_bus = 3'b111; #1;
        total++;
        if ({hrdata, hreadyout, hresponse} !== {32'h0, 1'b1, 1'b0}) begin
            $display("FAIL busy_idle got d=%h r=%b e=%b want d=0 r=1 e=0", hrdata, hreadyout, hresponse);
        end else passed++;
        tick();
        hreadyout_bus = 3'b111; hresp_bus = 3'b000;
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            sel = 2'($urandom_range(0, 3));
            htrans = 2'($urandom_range(0, 3));
            hrdata_bus = {$urandom, $urandom, $urandom};
            hreadyout_bus = 3'($urandom) | 3'($urandom);
            hresp_bus = 3'($urandom) & 3'($urandom);
            #1;
            model_expect();
            total++;
            if ({hrdata, hreadyout, hresponse} !== {exp_d, exp_r, exp_e}) begin
                $display("FAIL random_%0d got d=%h r=%b e=%b want d=%h r=%b e=%b", i, hrdata, hreadyout, hresponse, exp_d, exp_r, exp_e);
            end else passed++;
            tick();
        end
        htrans = 2'b00; hreadyout_bus = 3'b111;
        for (int i = 0; i < 3; i++) tick();
    endtask

    initial begin
        test_reset();
        test_routing();
        test_wait_states();
        test_default_slave();
        test_error_passthrough();
        test_idle_busy();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
